// File: rtl/fifo_pkg.sv
// Shared types and constants for the sync_fifo_flags FIFO family.
// Optional feature macro used by the top level: SYNC_FIFO_FWFT_EN.
package fifo_pkg;

    localparam int DEFAULT_AEMPTY_TH    = 2;
    // almost_full default sits this many entries below DEPTH
    localparam int DEFAULT_AFULL_MARGIN = 2;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for sync_fifo_flags: one synchronous write port and one
// asynchronous read address; the caller chooses whether to register the read.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     wr_en_i,
    input  logic [ptr_w(DEPTH)-1:0]  wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic [ptr_w(DEPTH)-1:0]  rd_addr_i,
    output logic [WIDTH-1:0]         rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with fill level, threshold flags and write-through when full.
// Define SYNC_FIFO_FWFT_EN for a first-word-fall-through read port.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = DEPTH - DEFAULT_AFULL_MARGIN,
    parameter int AEMPTY_TH = DEFAULT_AEMPTY_TH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [WIDTH-1:0]        wdata,
    input  logic                    rd_en,
    output logic [WIDTH-1:0]        rdata,
    output logic                    rd_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [ptr_w(DEPTH):0]   count,
    output logic                    wr_error,
    output logic                    rd_error
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_error_q, wr_error_d;
    logic             rd_error_q, rd_error_d;
    logic             rd_acc, wr_acc;
    logic [WIDTH-1:0] ram_rdata;
    fifo_status_t     status;

    // Flags come only from registered count, so they never see the inputs.
    assign status.full         = (count_q == DEPTH_C);
    assign status.empty        = (count_q == '0);
    assign status.almost_full  = (count_q >= AFULL_C);
    assign status.almost_empty = (count_q <= AEMPTY_C);

    // A pop frees the slot in the same cycle, which is what allows write-through.
    assign rd_acc = rd_en && !status.empty;
    assign wr_acc = wr_en && (!status.full || rd_acc);

    always_comb begin
        wr_ptr_d   = wr_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = rd_acc ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(wr_acc) - CW'(rd_acc);
        wr_error_d = wr_en && !wr_acc;
        rd_error_d = rd_en && !rd_acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wr_error_q <= 1'b0;
            rd_error_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wr_error_q <= wr_error_d;
            rd_error_q <= rd_error_d;
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wdata),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (ram_rdata)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign rdata    = status.empty ? '0 : ram_rdata;
    assign rd_valid = !status.empty;
`else
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rd_valid_q, rd_valid_d;

    always_comb begin
        rdata_d    = rd_acc ? ram_rdata : rdata_q;
        rd_valid_d = rd_acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rdata    = rdata_q;
    assign rd_valid = rd_valid_q;
`endif

    assign full         = status.full;
    assign empty        = status.empty;
    assign almost_full  = status.almost_full;
    assign almost_empty = status.almost_empty;
    assign count        = count_q;
    assign wr_error     = wr_error_q;
    assign rd_error     = rd_error_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags: directed table, random traffic
// and a mid-burst asynchronous reset, all checked against a queue model.
module tb_sync_fifo_flags;

    localparam int WIDTH     = 8;
    localparam int DEPTH     = 16;
    localparam int AFULL_TH  = 14;
    localparam int AEMPTY_TH = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             wr_en = 1'b0;
    logic             rd_en = 1'b0;
    logic [WIDTH-1:0] wdata = '0;
    logic [WIDTH-1:0] rdata;
    logic             rd_valid, full, empty, almost_full, almost_empty;
    logic [4:0]       count;
    logic             wr_error, rd_error;

    sync_fifo_flags #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AFULL_TH  (AFULL_TH),
        .AEMPTY_TH (AEMPTY_TH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wdata        (wdata),
        .rd_en        (rd_en),
        .rdata        (rdata),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .wr_error     (wr_error),
        .rd_error     (rd_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] wd;
        logic [4:0] count;
        logic       full;
        logic       empty;
        logic       afull;
        logic       aempty;
        logic       wr_err;
        logic       rd_err;
        logic       rd_valid;
        logic [7:0] rdata;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] mq[$];
    logic [7:0] m_rdata;
    int         n_vec = 0;
    int         n_err = 0;

    function automatic void fill_flags(inout vec_t v);
        int n;
        n = mq.size();
        v.count  = 5'(n);
        v.full   = (n == DEPTH);
        v.empty  = (n == 0);
        v.afull  = (n >= AFULL_TH);
        v.aempty = (n <= AEMPTY_TH);
    endfunction

    function automatic vec_t model_reset();
        vec_t v;
        mq.delete();
        m_rdata    = '0;
        v.wr       = 1'b0;
        v.rd       = 1'b0;
        v.wd       = '0;
        v.wr_err   = 1'b0;
        v.rd_err   = 1'b0;
        v.rd_valid = 1'b0;
        v.rdata    = '0;
        fill_flags(v);
        return v;
    endfunction

    // One clock of the FIFO expressed as queue operations.
    function automatic vec_t model_step(input logic wr, input logic rd, input logic [7:0] wd);
        vec_t v;
        bit   ra, wa;
        ra = rd && (mq.size() > 0);
        wa = wr && ((mq.size() < DEPTH) || ra);
        v.wr = wr;
        v.rd = rd;
        v.wd = wd;
`ifdef SYNC_FIFO_FWFT_EN
        if (ra) void'(mq.pop_front());
        if (wa) mq.push_back(wd);
        v.rd_valid = (mq.size() > 0);
        v.rdata    = (mq.size() > 0) ? mq[0] : 8'h00;
`else
        if (ra) m_rdata = mq.pop_front();
        if (wa) mq.push_back(wd);
        v.rd_valid = ra;
        v.rdata    = m_rdata;
`endif
        v.wr_err = wr && !wa;
        v.rd_err = rd && !ra;
        fill_flags(v);
        return v;
    endfunction

    task automatic add(input logic wr, input logic rd, input logic [7:0] wd);
        tbl.push_back(model_step(wr, rd, wd));
    endtask

    task automatic chk(input string tag, input string name, input logic [7:0] act, input logic [7:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
        end
    endtask

    task automatic check_vec(input string tag, input vec_t e);
        n_vec++;
        chk(tag, "count",        {3'b0, count},        {3'b0, e.count});
        chk(tag, "full",         {7'b0, full},         {7'b0, e.full});
        chk(tag, "empty",        {7'b0, empty},        {7'b0, e.empty});
        chk(tag, "almost_full",  {7'b0, almost_full},  {7'b0, e.afull});
        chk(tag, "almost_empty", {7'b0, almost_empty}, {7'b0, e.aempty});
        chk(tag, "wr_error",     {7'b0, wr_error},     {7'b0, e.wr_err});
        chk(tag, "rd_error",     {7'b0, rd_error},     {7'b0, e.rd_err});
        chk(tag, "rd_valid",     {7'b0, rd_valid},     {7'b0, e.rd_valid});
        chk(tag, "rdata",        rdata,                e.rdata);
    endtask

    task automatic apply(input vec_t v, input string tag);
        wr_en = v.wr;
        rd_en = v.rd;
        wdata = v.wd;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_vec(tag, v);
        $display("%s: wr=%0b rd=%0b wd=%02h -> count=%0d rdata=%02h rv=%0b werr=%0b rerr=%0b",
                 tag, v.wr, v.rd, v.wd, count, rdata, rd_valid, wr_error, rd_error);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   wp;

        #1 rst = 1'b1;
        #1;
        check_vec("reset", model_reset());
        @(negedge clk);
        rst = 1'b0;

        // Directed table: fill, overflow, drain, underflow, write-through.
        for (int i = 0; i < DEPTH; i++) add(1'b1, 1'b0, 8'($urandom_range(10, 50)));
        add(1'b1, 1'b0, 8'hEE);
        add(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < DEPTH; i++) add(1'b0, 1'b1, 8'h00);
        add(1'b0, 1'b1, 8'h00);
        add(1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 8'h77);
        add(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < DEPTH; i++) add(1'b1, 1'b0, 8'(8'h80 + i));
        for (int i = 0; i < 4; i++) add(1'b1, 1'b1, 8'(8'hC0 + i));
        for (int i = 0; i < DEPTH + 1; i++) add(1'b0, 1'b1, 8'h00);

        foreach (tbl[i]) apply(tbl[i], "tbl");

        // Random traffic with alternating fill/drain bias.
        for (int i = 0; i < 400; i++) begin
            wp = ((i / 50) % 2 == 0) ? 80 : 25;
            v = model_step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp),
                           8'($urandom));
            apply(v, "rnd");
        end

        // Asynchronous reset with nine words queued.
        while (mq.size() > 0) apply(model_step(1'b0, 1'b1, 8'h00), "drain");
        for (int i = 0; i < 9; i++) apply(model_step(1'b1, 1'b0, 8'(8'h30 + i)), "pre_rst");
        wr_en = 1'b1;
        wdata = 8'hF0;
        #2 rst = 1'b1;
        #1;
        check_vec("async_rst", model_reset());
        wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        apply(model_step(1'b1, 1'b0, 8'h5A), "post_rst_wr");
        apply(model_step(1'b0, 1'b1, 8'h00), "post_rst_rd");
        apply(model_step(1'b0, 1'b0, 8'h00), "post_rst_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
